// File: rtl/secded_pkg.sv
// Shared sizing helpers and decode-result type for the pipelined SECDED decoder.
package secded_pkg;

    localparam int unsigned MaxDw = 512;
    localparam int unsigned MaxSw = 11;

    typedef struct packed {
        logic [MaxDw-1:0] data;
        logic             sec;
        logic             ded;
        logic [MaxSw-1:0] syn;
    } dec_res_t;

    // r + 1, where r is the smallest value with 2^r >= dw + r + 1
    function automatic int unsigned ecc_width(input int unsigned dw);
        int unsigned r;
        r = 1;
        for (int k = 0; k < 31; k++) begin
            if ((32'd1 << r) < dw + r + 1) r = r + 1;
        end
        return r + 1;
    endfunction

    // Hamming position of data bit i: the i-th non-power-of-two position (3, 5, 6, 7, 9, ...)
    function automatic int unsigned data_col(input int unsigned i);
        int unsigned pos;
        pos = i + 3;
        for (int unsigned j = 2; j < 31; j++) begin
            if ((32'd1 << j) <= pos) pos = pos + 1;
        end
        return pos;
    endfunction

endpackage

// File: rtl/secded_dec_core.sv
// Combinational SECDED logic: syndrome/parity of an incoming codeword, and
// correction of a registered word from its stored syndrome and parity.
module secded_dec_core
    import secded_pkg::*;
#(
    parameter int unsigned DW = 32,
    localparam int unsigned EW = ecc_width(DW)
) (
    input  logic [DW+EW-1:0] code,
    output logic [EW-2:0]    code_syn,
    output logic             code_par,
    input  logic [DW-1:0]    raw,
    input  logic [EW-2:0]    syn,
    input  logic             par,
    output dec_res_t         res
);

    localparam logic [EW-2:0] SynOne = {{(EW-2){1'b0}}, 1'b1};

    int unsigned col;
    logic        hit;

    always_comb begin
        col      = 0;
        code_syn = code[DW+EW-2:DW];
        for (int unsigned i = 0; i < DW; i++) begin
            col = data_col(i);
            for (int unsigned j = 0; j < EW - 1; j++) begin
                if (col[j]) code_syn[j] = code_syn[j] ^ code[i];
            end
        end
        code_par = ^code;
    end

    always_comb begin
        res                = '0;
        res.data[DW-1:0]   = raw;
        res.syn[EW-2:0]    = syn;
        hit                = 1'b0;
        if (syn == '0) begin
            res.sec = par;
        end else if (!par) begin
            res.ded = 1'b1;
        end else begin
            for (int unsigned i = 0; i < DW; i++) begin
                if (data_col(i) == 32'(syn)) begin
                    res.data[i] = ~raw[i];
                    hit         = 1'b1;
                end
            end
            // A lone check-bit error points at a power-of-two position
            if ((syn & (syn - SynOne)) == '0) hit = 1'b1;
            res.sec = hit;
            res.ded = ~hit;
        end
    end

endmodule

// File: rtl/secded_dec_pipe.sv
// Two-stage SECDED decoder with valid/ready flow control, per-word ECC bypass,
// saturating SEC/DED counters and a first-error log.
module secded_dec_pipe
    import secded_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned TW = 8,
    parameter int unsigned CW = 16,
    localparam int unsigned EW = ecc_width(DW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW+EW-1:0] in_data,
    input  logic [TW-1:0]    in_tag,
    input  logic             in_ecc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [TW-1:0]    out_tag,
    output logic             out_sec,
    output logic             out_ded,
    output logic [CW-1:0]    sec_cnt,
    output logic [CW-1:0]    ded_cnt,
    output logic             log_valid,
    output logic             log_ded,
    output logic [TW-1:0]    log_tag,
    output logic [EW-2:0]    log_syn,
    input  logic             clr
);

    logic          s1_valid_q, s1_ecc_q, s1_par_q;
    logic [EW-2:0] s1_syn_q;
    logic [DW-1:0] s1_data_q;
    logic [TW-1:0] s1_tag_q;
    logic          s2_valid_q, s2_sec_q, s2_ded_q;
    logic [DW-1:0] s2_data_q;
    logic [TW-1:0] s2_tag_q;
    logic [EW-2:0] s2_syn_q;
    logic [CW-1:0] sec_cnt_d, sec_cnt_q, ded_cnt_d, ded_cnt_q;
    logic          log_valid_d, log_valid_q, log_ded_d, log_ded_q;
    logic [TW-1:0] log_tag_d, log_tag_q;
    logic [EW-2:0] log_syn_d, log_syn_q;
    logic [EW-2:0] in_syn;
    logic          in_par, s2_adv, in_hs, s1_hs, out_hs, unused_res_bits;
    dec_res_t      res;

    secded_dec_core #(.DW(DW)) u_core (
        .code     (in_data),
        .code_syn (in_syn),
        .code_par (in_par),
        .raw      (s1_data_q),
        .syn      (s1_syn_q),
        .par      (s1_par_q),
        .res      (res)
    );

    assign s2_adv          = ~s2_valid_q | out_ready;
    assign in_ready        = ~s1_valid_q | s2_adv;
    assign in_hs           = in_valid & in_ready;
    assign s1_hs           = s1_valid_q & s2_adv;
    assign out_hs          = s2_valid_q & out_ready;
    assign unused_res_bits = ^{res.data, res.syn};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_ecc_q   <= 1'b0;
            s1_par_q   <= 1'b0;
            s1_syn_q   <= '0;
            s1_data_q  <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_sec_q   <= 1'b0;
            s2_ded_q   <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
            s2_syn_q   <= '0;
        end else begin
            if (in_ready) s1_valid_q <= in_valid;
            if (in_hs) begin
                s1_data_q <= in_data[DW-1:0];
                s1_tag_q  <= in_tag;
                s1_ecc_q  <= in_ecc_en;
                s1_syn_q  <= in_syn;
                s1_par_q  <= in_par;
            end
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (s1_hs) begin
                s2_tag_q  <= s1_tag_q;
                s2_data_q <= s1_ecc_q ? res.data[DW-1:0] : s1_data_q;
                s2_sec_q  <= s1_ecc_q & res.sec;
                s2_ded_q  <= s1_ecc_q & res.ded;
                s2_syn_q  <= s1_ecc_q ? res.syn[EW-2:0] : '0;
            end
        end
    end

    // Accounting happens on the output handshake so a stalled word counts once
    always_comb begin
        sec_cnt_d   = sec_cnt_q;
        ded_cnt_d   = ded_cnt_q;
        log_valid_d = log_valid_q;
        log_ded_d   = log_ded_q;
        log_tag_d   = log_tag_q;
        log_syn_d   = log_syn_q;
        if (clr) begin
            sec_cnt_d   = '0;
            ded_cnt_d   = '0;
            log_valid_d = 1'b0;
            log_ded_d   = 1'b0;
            log_tag_d   = '0;
            log_syn_d   = '0;
        end else if (out_hs) begin
            if (s2_sec_q && sec_cnt_q != '1) sec_cnt_d = sec_cnt_q + 1'b1;
            if (s2_ded_q && ded_cnt_q != '1) ded_cnt_d = ded_cnt_q + 1'b1;
            if ((s2_sec_q || s2_ded_q) && (!log_valid_q || (s2_ded_q && !log_ded_q))) begin
                log_valid_d = 1'b1;
                log_ded_d   = s2_ded_q;
                log_tag_d   = s2_tag_q;
                log_syn_d   = s2_syn_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt_q   <= '0;
            ded_cnt_q   <= '0;
            log_valid_q <= 1'b0;
            log_ded_q   <= 1'b0;
            log_tag_q   <= '0;
            log_syn_q   <= '0;
        end else begin
            sec_cnt_q   <= sec_cnt_d;
            ded_cnt_q   <= ded_cnt_d;
            log_valid_q <= log_valid_d;
            log_ded_q   <= log_ded_d;
            log_tag_q   <= log_tag_d;
            log_syn_q   <= log_syn_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;
    assign out_sec   = s2_sec_q;
    assign out_ded   = s2_ded_q;
    assign sec_cnt   = sec_cnt_q;
    assign ded_cnt   = ded_cnt_q;
    assign log_valid = log_valid_q;
    assign log_ded   = log_ded_q;
    assign log_tag   = log_tag_q;
    assign log_syn   = log_syn_q;

endmodule

// File: doc/secded_dec_pipe.md
# secded_dec_pipe

Parametrised, pipelined SECDED (Hamming + overall parity) decoder with valid/ready flow control, per-word error flags, saturating error counters and a first-error log. It sits between ECC-protected storage (SRAM/FIFO read port) and the consumer. It generalises the fixed-width single-register decoder to any data width, adds backpressure and a per-word ECC bypass, and adds error accounting for software.

## Interface
- DW, 32, data width in bits (≥ 4).
- TW, 8, width of the sideband tag carried alongside each word (address or ID).
- CW, 16, width of each error counter.
- EW, derived localparam, not overridable: r + 1, where r is the smallest value with 2^r ≥ DW + r + 1. Examples: 32→7, 64→8, 8→5.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  decoder can accept a word.
- in_data  in  DW+EW  bits [DW-1:0] data, [DW+EW-2:DW] Hamming check bits, [DW+EW-1] overall parity.
- in_tag  in  TW  sideband, passed through unchanged.
- in_ecc_en  in  1  1 = decode; 0 = bypass for this word.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DW  corrected data.
- out_tag  out  TW  tag of the word.
- out_sec  out  1  single error corrected in this word.
- out_ded  out  1  double error detected; out_data is uncorrected raw data.
- sec_cnt  out  CW  saturating count of SEC words.
- ded_cnt  out  CW  saturating count of DED words.
- log_valid  out  1  error log holds an entry.
- log_ded  out  1  logged entry is a DED.
- log_tag  out  TW  tag of the logged word.
- log_syn  out  EW-1  syndrome of the logged word.
- clr  in  1  synchronous clear of the counters and the log.

## Operation
- Code layout: data bit i occupies the i-th non-power-of-two Hamming position (3, 5, 6, 7, 9, …). Check bit j covers every position with bit j set. The overall parity bit makes the XOR of all DW+EW bits equal to 0.
- Syndrome: s[j] = check[j] XOR (XOR of the data bits covered by j). Overall parity p = XOR of all in_data bits.
- Decode table:
  - s = 0, p = 0: clean.
  - s ≠ 0, p = 1, s matches a data column: flip that data bit; sec = 1.
  - s ≠ 0, p = 1, s is a power of two: check-bit error; data unchanged; sec = 1.
  - s = 0, p = 1: parity-bit error; data unchanged; sec = 1.
  - s ≠ 0, p = 0: ded = 1.
  - s ≠ 0, p = 1, s matches no position (beyond DW+EW-1): ded = 1.
- sec and ded are never both 1.
- Bypass (ecc_en = 0, sampled at input handshake): data passes through raw; sec = ded = 0; no counting; no logging.
- Counters and log update only on the output handshake (out_valid & out_ready), so each word is counted once.
- Counters:
  - +1 on sec or ded respectively.
  - Saturate at 2^CW − 1.
  - clr in the same cycle wins: result 0, the increment is lost.
- Log:
  - Captures tag, syndrome and type of the first error word while log_valid = 0.
  - A DED replaces a held SEC entry.
  - A later DED never replaces a held DED.
  - clr empties the log and wins over a same-cycle capture.

## Timing
- Two register stages:
  - S1 registers syndrome, parity, raw data, tag and ecc_en.
  - S2 registers the corrected data and flags.
- Latency: 2 cycles from input handshake to out_valid, with no stall.
- Throughput: 1 word/cycle.
- Each stage advances when it is empty or the downstream stage advances. in_ready = ~s1_valid | s1_advance (combinational from out_ready; no bubble under continuous flow).
- Under out_ready = 0:
  - At most 2 words held.
  - out_* stable until the handshake.
  - in_ready drops once both stages are full.
- Reset values: all valid flags 0, in_ready 1 once out of reset, all data/tag/flags/counters/log fields 0.
- Reset mid-operation discards in-flight words.

## Structure
- Package secded_pkg holds:
  - function ecc_width(DW) returning EW;
  - function data_col(i) returning the Hamming position of data bit i;
  - typedef for the decode-result struct {data, sec, ded, syn}.
- One sub-module, secded_dec_core: purely combinational syndrome, parity and correction, instanced between S1 and S2.
- The top level holds the pipeline, handshake, counters and log.

## Test plan
- DW=32: encode 32'hDEADBEEF, flip data bit 17 → out_data 32'hDEADBEEF, out_sec=1, sec_cnt=1, log_syn = position of bit 17.
- Flip data bits 0 and 5 → out_ded=1, out_data equals the raw corrupted data, ded_cnt=1, log_ded=1 (replaces the earlier SEC entry).
- Flip the parity bit only, then check bit 2 only → two words with out_sec=1 and out_data unchanged.
- Stream 8 words while toggling out_ready 1010… → no loss or duplication, order kept, out_* stable while stalled.
- CW=2: inject 5 SEC words → sec_cnt saturates at 3; clr asserted with a 6th SEC handshake → sec_cnt=0, log_valid=0.
- ecc_en=0 with a 2-bit flip → raw data out, sec=ded=0, counters unchanged. Assert rst_n low mid-stream → out_valid=0 and counters=0 asynchronously.
